// File: rtl/mod_sequencer.sv
// Multi-cycle operation sequencer that drives an external combinational ALU; mod is
// computed by repeated compare/subtract. Optional MOD_ITER_LIMIT_EN bounds the loop at MAX_ITER.
module mod_sequencer #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [1:0]       state_dbg
);
    // Handshake: start is a request strobe sampled only while busy=0; done pulses for
    // exactly one cycle with result/err valid, and those stay held until the next done.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CMP  = 2'd2,
        SUB  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, rem;
    logic             fin, fin_err, skip, iter_hit;
    logic [WIDTH-1:0] fin_result;

    // Operands the subtract loop cannot handle finish immediately with err.
    assign skip = (b_q == '0) || b_q[WIDTH-1] || a_q[WIDTH-1];

`ifdef MOD_ITER_LIMIT_EN
    localparam int CW = $clog2(MAX_ITER + 1);
    logic [CW-1:0] iter_cnt;
    assign iter_hit = (iter_cnt == CW'(MAX_ITER));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            iter_cnt <= '0;
        else if (state == IDLE && start)
            iter_cnt <= '0;
        else if (state == SUB)
            iter_cnt <= iter_cnt + 1'b1;
    end
`else
    logic unused_max_iter;
    assign unused_max_iter = (MAX_ITER > 0);
    assign iter_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        alu_op     = 3'b000;
        alu_a      = '0;
        alu_b      = '0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_result = '0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (op == OP_MOD) ? CMP : EXEC;
            end
            EXEC: begin
                alu_op     = op_q;
                alu_a      = a_q;
                alu_b      = b_q;
                fin        = 1'b1;
                fin_result = alu_result;
                state_nxt  = IDLE;
            end
            CMP: begin
                alu_op = OP_LT;
                alu_a  = rem;
                alu_b  = b_q;
                if (skip) begin
                    fin        = 1'b1;
                    fin_err    = 1'b1;
                    fin_result = a_q;
                    state_nxt  = IDLE;
                end else if (alu_result[0]) begin
                    fin        = 1'b1;
                    fin_result = rem;
                    state_nxt  = IDLE;
                end else if (iter_hit) begin
                    fin        = 1'b1;
                    fin_err    = 1'b1;
                    fin_result = rem;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = SUB;
                end
            end
            SUB: begin
                alu_op    = OP_SUB;
                alu_a     = rem;
                alu_b     = b_q;
                state_nxt = CMP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= 3'b000;
            a_q    <= '0;
            b_q    <= '0;
            rem    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            done  <= fin;
            if (fin) begin
                result <= fin_result;
                err    <= fin_err;
            end
            if (state == IDLE && start) begin
                op_q <= op;
                a_q  <= a_in;
                b_q  <= b_in;
                rem  <= a_in;
            end else if (state == SUB) begin
                rem <= alu_result;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
